busca_instrucao: RTL and testbench

Instruction-fetch (IF) stage of the 5-stage RV32 pipeline, directly upstream of ID. Generates sequential PCs, runs a request/ready handshake with instruction memory, and buffers fetched words in a small prefetch queue. It presents {pc, instruction} to ID (decode, immediate generation) with a valid/stall handshake. It accepts PC redirects from branch resolution, including in-flight discard when a redirect lands mid-access.

---
 rtl/busca_instrucao.sv | 133 +++++++++++++
 tb/tb_busca_instrucao.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/busca_instrucao.sv
// busca_instrucao: instruction-fetch stage of the RV32 5-stage pipeline.
// Generates sequential PCs, handshakes with instruction memory and buffers
// fetched words in a DEPTH-entry prefetch queue whose head feeds ID.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   imem_req/addr     fetch request and word-aligned address (out)
//   imem_ready/rdata  request completion and instruction word (in)
//   redirect/_pc      taken branch/jump from EX and its target PC
//   stall             ID cannot accept the head entry this cycle
//   if_valid/pc/instr head entry presented to ID
//   perf_fetched, perf_discarded  only when BUSCA_PERF_EN is defined
//
// Optional feature macro: BUSCA_PERF_EN (fetch/discard counters).
module busca_instrucao #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
`ifdef BUSCA_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t             state, state_next;
  logic [31:0]        fetch_pc;
  logic [31:0]        drain_addr;
  logic [31:0]        pc_q    [DEPTH];
  logic [31:0]        instr_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               req_int, done, push, pop, has_data;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Next-state logic. A DRAIN ends when the abandoned access completes, even
  // if a further redirect arrives in that same cycle (it only moves fetch_pc).
  always_comb begin
    state_next = state;
    case (state)
      FETCH: if (redirect && req_int && !imem_ready) state_next = DRAIN;
      DRAIN: if (imem_ready) state_next = FETCH;
    endcase
  end

  // Outputs and handshake qualifiers. Request issue looks only at state,
  // registered count and fetch_pc; rst merely gates the port off.
  always_comb begin
    req_int   = (state == DRAIN) || (count < FULL);
    imem_req  = req_int && !rst;
    imem_addr = (state == DRAIN) ? drain_addr : fetch_pc;
    has_data  = (count != '0);
    if_valid  = has_data && !rst;
    if_pc     = pc_q[rd_ptr];
    if_instr  = instr_q[rd_ptr];
    done      = req_int && imem_ready;
    push      = (state == FETCH) && done && !redirect;
    pop       = has_data && !stall && !redirect;
  end

  // Fetch PC and prefetch queue
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      drain_addr <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      pc_q       <= '{default: '0};
      instr_q    <= '{default: '0};
    end else if (redirect) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      // Keep the in-flight address for a possible DRAIN; in DRAIN it is
      // already latched and must not change.
      if (state == FETCH) drain_addr <= fetch_pc;
    end else begin
      if (push) begin
        pc_q[wr_ptr]    <= fetch_pc;
        instr_q[wr_ptr] <= imem_rdata;
        wr_ptr          <= wr_ptr + 1'b1;
        fetch_pc        <= fetch_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef BUSCA_PERF_EN
  // Discards: completions dropped by redirect or DRAIN, plus flushed entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      perf_discarded <= perf_discarded
                      + (redirect ? 32'(count) : 32'd0)
                      + ((done && (redirect || state == DRAIN)) ? 32'd1 : 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_busca_instrucao.sv
module tb_busca_instrucao;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_ready, redirect, stall, if_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, if_pc, if_instr;
`ifdef BUSCA_PERF_EN
  logic [31:0] perf_fetched, perf_discarded;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  busca_instrucao #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
`ifdef BUSCA_PERF_EN
    , .perf_fetched(perf_fetched), .perf_discarded(perf_discarded)
`endif
  );

  // Reference model: a queue of fetched words, the next fetch PC and an
  // "abandoned access outstanding" flag with its address.
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  ent_t        mq[$];
  logic [31:0] m_fpc;
  bit          m_drain;
  logic [31:0] m_daddr;
  int unsigned m_fetched, m_disc;

  function automatic bit m_req();
    return m_drain || (mq.size() < DEPTH);
  endfunction

  function automatic logic [31:0] m_addr();
    return m_drain ? m_daddr : m_fpc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_fpc = RPC; m_drain = 0; m_daddr = '0;
    m_fetched = 0; m_disc = 0;
  endtask

  task automatic check_model();
    chk("if_valid", 32'(if_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("if_pc", if_pc, mq[0].pc);
      chk("if_instr", if_instr, mq[0].instr);
    end
    chk("imem_req", 32'(imem_req), 32'(m_req()));
    if (m_req()) chk("imem_addr", imem_addr, m_addr());
`ifdef BUSCA_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_discarded", perf_discarded, m_disc);
`endif
  endtask

  // Drive inputs and check outputs in the middle of the cycle.
  task automatic step_begin(input logic rdy, input logic stl, input logic rd,
                            input logic [31:0] rpc);
    imem_ready = rdy; stall = stl; redirect = rd; redirect_pc = rpc;
    @(negedge clk);
    check_model();
  endtask

  // Advance the clock and update the model from the applied inputs.
  task automatic step_end();
    bit req, done;
    @(posedge clk);
    req  = m_req();
    done = req && imem_ready;
    if (redirect) begin
      m_disc += mq.size();
      if (done) m_disc++;
      mq.delete();
      if (!m_drain && req && !imem_ready) begin
        m_drain = 1; m_daddr = m_fpc;
      end else if (m_drain && imem_ready) begin
        m_drain = 0;
      end
      m_fpc = redirect_pc & 32'hFFFF_FFFC;
    end else if (m_drain) begin
      if (imem_ready) begin m_drain = 0; m_disc++; end
    end else begin
      if (mq.size() != 0 && !stall) void'(mq.pop_front());
      if (done) begin
        mq.push_back('{pc: m_fpc, instr: mem_word(m_fpc)});
        m_fpc += 32'd4;
        m_fetched++;
      end
    end
    #1;
  endtask

  task automatic cyc(input logic rdy, input logic stl, input logic rd,
                     input logic [31:0] rpc);
    step_begin(rdy, stl, rd, rpc);
    step_end();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; imem_ready = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      if (i > 0) begin
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    m_reset();
  endtask

  typedef struct {
    logic rdy; logic stl; logic rd; logic [31:0] rpc;
    logic req; logic [31:0] addr; logic valid; logic [31:0] pc;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Hand-derived sequence from reset release (RESET_PC=0, DEPTH=2).
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b1, 32'h000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h004};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h103, 1'b1, 32'h008, 1'b0, 32'h000};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h008, 1'b0, 32'h000};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h008, 1'b0, 32'h000};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h203, 1'b1, 32'h104, 1'b1, 32'h100};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h000};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h000};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h208, 1'b1, 32'h200};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h208, 1'b1, 32'h200};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h204};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h20C, 1'b1, 32'h208};

    do_reset(2);

    for (int i = 0; i < 15; i++) begin
      step_begin(tbl[i].rdy, tbl[i].stl, tbl[i].rd, tbl[i].rpc);
      chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 32'(if_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_pc", i), if_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_instr", i), if_instr, mem_word(tbl[i].pc));
      end
      step_end();
    end

    // Wait-state memory: ready every third cycle.
    do_reset(2);
    for (int i = 0; i < 60; i++) cyc(i % 3 == 2, 1'b0, 1'b0, 32'h0);

    // Stall with a ready memory: queue fills, request drops, then drains.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    step_begin(1'b1, 1'b1, 1'b0, 32'h0);
    chk("full_req_low", 32'(imem_req), 32'd0);
    step_end();
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);

    // Reset asserted while draining an abandoned access.
    cyc(1'b0, 1'b0, 1'b1, 32'h300);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    do_reset(2);
    step_begin(1'b1, 1'b0, 1'b0, 32'h0);
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, RPC);
    step_end();

    // Randomized traffic against the model, including the 32-bit PC wrap.
    cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF5);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset(2);
      else if ($urandom_range(0, 15) == 0)
        cyc($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, 1'b1,
            ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | ($urandom & 32'hF) : $urandom);
      else
        cyc($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, 1'b0, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
